rvj1_timer_multi: RTL and testbench

- Parametrised multi-channel timer peripheral for the rvj1 SoC, replacing the single fixed timer.
- Sits on the SoC Wishbone bus as a classic single-cycle slave.
- Provides NUM_CH independent up-counters, each with:
  - a programmable prescaler and compare/wrap value
  - periodic or one-shot mode
  - a sticky match flag and a maskable interrupt output

---
 rtl/rvj1_timer_multi.sv | 182 ++++++++++++++++++
 tb/tb_rvj1_timer_multi.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvj1_timer_multi.sv
// rvj1_timer_multi: NUM_CH-channel Wishbone timer, prescaler, compare/wrap, one-shot, IRQ.
// Optional DUTY register and pwm_o are built when TIMER_PWM_EN is defined.
module rvj1_timer_multi #(
  parameter int NUM_CH  = 2,
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [7:0]        wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic [NUM_CH-1:0] irq_o,
  output logic [NUM_CH-1:0] pwm_o
);

  localparam logic [2:0] OFF_CTRL = 3'd0;
  localparam logic [2:0] OFF_CMP  = 3'd1;
  localparam logic [2:0] OFF_CNT  = 3'd2;
  localparam logic [2:0] OFF_STAT = 3'd3;

  logic               req;
  logic [2:0]         ch_a;
  logic [2:0]         off_a;
  logic               unused_adr;
  logic               is_ctrl;
  logic               is_cmp;
  logic               is_cnt;
  logic               is_stat;
  logic [31:0]        rdata;

  logic [NUM_CH-1:0]  en;
  logic [NUM_CH-1:0]  periodic;
  logic [NUM_CH-1:0]  irq_en;
  logic [NUM_CH-1:0]  match;
  logic [NUM_CH-1:0]  tick;
  logic [NUM_CH-1:0]  hit;
  logic [NUM_CH-1:0]  wr_ch;
  logic [PRESC_W-1:0] presc   [NUM_CH];
  logic [PRESC_W-1:0] pre_cnt [NUM_CH];
  logic [WIDTH-1:0]   cmp     [NUM_CH];
  logic [WIDTH-1:0]   count   [NUM_CH];
  logic [31:0]        ctrl_v  [NUM_CH];

`ifdef TIMER_PWM_EN
  localparam logic [2:0] OFF_DUTY = 3'd4;
  logic               is_duty;
  logic [WIDTH-1:0]   duty    [NUM_CH];
  logic [NUM_CH-1:0]  pwm_q;
`endif

  function automatic logic [31:0] merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign ch_a       = wb_adr_i[7:5];
  assign off_a      = wb_adr_i[4:2];
  assign unused_adr = ^wb_adr_i[1:0];
  assign is_ctrl    = (off_a == OFF_CTRL);
  assign is_cmp     = (off_a == OFF_CMP);
  assign is_cnt     = (off_a == OFF_CNT);
  assign is_stat    = (off_a == OFF_STAT);
`ifdef TIMER_PWM_EN
  assign is_duty    = (off_a == OFF_DUTY);
  assign pwm_o      = pwm_q;
`else
  assign pwm_o      = '0;
`endif

  assign irq_o = match & irq_en;

  // Per-channel write select, prescaler tick, match event and CTRL view.
  // A COUNT write in the same cycle suppresses the match.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_ch[c] = req & wb_we_i & (ch_a == 3'(c));
      tick[c]  = en[c] & (pre_cnt[c] == presc[c]);
      hit[c]   = tick[c] & (count[c] == cmp[c])
               & ~(wr_ch[c] & is_cnt);
      ctrl_v[c]              = '0;
      ctrl_v[c][0]           = en[c];
      ctrl_v[c][1]           = periodic[c];
      ctrl_v[c][2]           = irq_en[c];
      ctrl_v[c][8 +: PRESC_W] = presc[c];
    end
  end

  // Read mux; unmapped offsets and absent channels read 0.
  always_comb begin
    rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_a == 3'(c)) begin
        unique case (1'b1)
          is_ctrl: rdata = ctrl_v[c];
          is_cmp:  rdata = 32'(cmp[c]);
          is_cnt:  rdata = 32'(count[c]);
          is_stat: rdata = {31'b0, match[c]};
`ifdef TIMER_PWM_EN
          is_duty: rdata = 32'(duty[c]);
`endif
          default: rdata = '0;
        endcase
      end
    end
  end

  // Bus handshake and all channel state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        en[c]       <= 1'b0;
        periodic[c] <= 1'b0;
        irq_en[c]   <= 1'b0;
        match[c]    <= 1'b0;
        presc[c]    <= '0;
        pre_cnt[c]  <= '0;
        cmp[c]      <= '0;
        count[c]    <= '0;
`ifdef TIMER_PWM_EN
        duty[c]     <= '0;
        pwm_q[c]    <= 1'b0;
`endif
      end
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req & ~wb_we_i) ? rdata : '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ch[c] & is_ctrl) begin
          en[c]       <= (wb_sel_i[0] ? wb_dat_i[0] : en[c])
                       & ~(hit[c] & ~periodic[c]);
          periodic[c] <= wb_sel_i[0] ? wb_dat_i[1] : periodic[c];
          irq_en[c]   <= wb_sel_i[0] ? wb_dat_i[2] : irq_en[c];
          presc[c]    <= PRESC_W'(merge(ctrl_v[c], wb_dat_i, wb_sel_i) >> 8);
          pre_cnt[c]  <= '0;
        end else begin
          if (hit[c] & ~periodic[c]) en[c] <= 1'b0;
          if (tick[c]) pre_cnt[c] <= '0;
          else if (en[c]) pre_cnt[c] <= pre_cnt[c] + PRESC_W'(1);
        end

        if (wr_ch[c] & is_cmp)
          cmp[c] <= WIDTH'(merge(32'(cmp[c]), wb_dat_i, wb_sel_i));

        if (wr_ch[c] & is_cnt)
          count[c] <= WIDTH'(merge(32'(count[c]), wb_dat_i, wb_sel_i));
        else if (hit[c])
          count[c] <= '0;
        else if (tick[c])
          count[c] <= count[c] + WIDTH'(1);

        if (hit[c])
          match[c] <= 1'b1;
        else if (wr_ch[c] & is_stat & wb_sel_i[0] & wb_dat_i[0])
          match[c] <= 1'b0;

`ifdef TIMER_PWM_EN
        if (wr_ch[c] & is_duty)
          duty[c] <= WIDTH'(merge(32'(duty[c]), wb_dat_i, wb_sel_i));
        pwm_q[c] <= en[c] & (count[c] < duty[c]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_rvj1_timer_multi.sv
// tb_rvj1_timer_multi: scoreboard bench for rvj1_timer_multi.
// Expected read data is queued at issue time and compared once the read acks.
module tb_rvj1_timer_multi;
  localparam int NUM_CH  = 2;
  localparam int WIDTH   = 32;
  localparam int PRESC_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cyc;
  logic              stb;
  logic              we;
  logic [7:0]        adr;
  logic [31:0]       dat_i;
  logic [3:0]        sel;
  logic [31:0]       dat_o;
  logic              ack;
  logic [NUM_CH-1:0] irq;
  logic [NUM_CH-1:0] pwm;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int eb0 = 0;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] obs_q[$];

  rvj1_timer_multi #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESC_W(PRESC_W)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_dat_o(dat_o), .wb_ack_o(ack),
    .irq_o(irq), .pwm_o(pwm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int cap_now();
    return cyc_cnt + (ack ? 2 : 1);
  endfunction

  task automatic push_exp(input string nm, input logic [31:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    exp_q.push_back(e);
  endtask

  task automatic bus(input logic w, input logic [7:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    int n;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    @(negedge clk);
    n = 0;
    while (!ack && n < 4) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ack) begin
      errors++;
      $display("FAIL bus_ack adr=%h: got no ack, want ack", a);
    end
    if (!w) obs_q.push_back(dat_o);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 4'hF);
  endtask

  task automatic rd(input logic [7:0] a);
    bus(1'b0, a, 32'h0, 4'hF);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] o;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat_i = '0; sel = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", ack); end
    checks++;
    if (dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h want 0", dat_o); end
    checks++;
    if (irq !== '0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
    checks++;
    if (pwm !== '0) begin errors++; $display("FAIL rst_pwm: got %b want 0", pwm); end
    rst = 1'b0;
    push_exp("rst_ctrl0", 32'h0);  rd(8'h00);
    push_exp("rst_count0", 32'h0); rd(8'h08);
    push_exp("rst_ctrl1", 32'h0);  rd(8'h20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: got no data want %h", e.nm, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got %h want %h", e.nm, o, e.v); end
      end
    end
  endtask

  task automatic test_periodic();
    exp_t e;
    logic [31:0] o;
    int n;
    wr(8'h04, 32'h15);
    wr(8'h00, 32'h7);
    eb0 = cyc_cnt;
    n = 0;
    while (!irq[0] && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (cyc_cnt - eb0 != 22) begin
      errors++; $display("FAIL per_first_irq: got delay %0d want 22", cyc_cnt - eb0);
    end
    wr(8'h0C, 32'h1);
    checks++;
    if (irq[0] !== 1'b0) begin errors++; $display("FAIL per_w1c_irq: got %b want 0", irq[0]); end
    push_exp("per_count", 32'((cap_now() - 1 - eb0) % 22)); rd(8'h08);
    push_exp("per_status", 32'h0); rd(8'h0C);
    push_exp("per_cmp", 32'h15); rd(8'h04);
    n = 0;
    while (!irq[0] && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (cyc_cnt - eb0 != 44) begin
      errors++; $display("FAIL per_second_irq: got delay %0d want 44", cyc_cnt - eb0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: got no data want %h", e.nm, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got %h want %h", e.nm, o, e.v); end
      end
    end
  endtask

  task automatic test_oneshot();
    exp_t e;
    logic [31:0] o;
    int n;
    int eb1;
    wr(8'h24, 32'h3);
    wr(8'h20, 32'h405);
    eb1 = cyc_cnt;
    n = 0;
    while (!irq[1] && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (cyc_cnt - eb1 != 20) begin
      errors++; $display("FAIL os_irq: got delay %0d want 20", cyc_cnt - eb1);
    end
    push_exp("os_ctrl", 32'h404); rd(8'h20);
    push_exp("os_count", 32'h0); rd(8'h28);
    push_exp("os_status", 32'h1); rd(8'h2C);
    push_exp("os_ch0_count", 32'((cap_now() - 1 - eb0) % 22)); rd(8'h08);
    repeat (12) @(negedge clk);
    push_exp("os_count_held", 32'h0); rd(8'h28);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: got no data want %h", e.nm, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got %h want %h", e.nm, o, e.v); end
      end
    end
  endtask

  task automatic test_boundaries();
    exp_t e;
    logic [31:0] o;
    int n;
    int ebw;
    int ew;
    wr(8'h2C, 32'h1);
    push_exp("cmp0_cleared", 32'h0); rd(8'h2C);
    wr(8'h24, 32'h0);
    wr(8'h20, 32'h3);
    wr(8'h2C, 32'h1);
    push_exp("cmp0_match_beats_w1c", 32'h1); rd(8'h2C);
    push_exp("cmp0_count", 32'h0); rd(8'h28);
    wr(8'h20, 32'h0);
    wr(8'h24, 32'h5);
    wr(8'h28, 32'hFFFF_FFF0);
    wr(8'h2C, 32'h1);
    wr(8'h20, 32'h7);
    ebw = cyc_cnt;
    push_exp("wrap_count", 32'hFFFF_FFF0 + 32'(cap_now() - 1 - ebw)); rd(8'h28);
    n = 0;
    while (!irq[1] && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (cyc_cnt - ebw != 22) begin
      errors++; $display("FAIL wrap_match: got delay %0d want 22", cyc_cnt - ebw);
    end
    push_exp("wrap_after", 32'((cap_now() - 1 - ebw - 22) % 6)); rd(8'h28);
    wr(8'h28, 32'h100);
    ew = cyc_cnt;
    push_exp("cnt_wr_on_tick", 32'h100 + 32'(cap_now() - 1 - ew)); rd(8'h28);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: got no data want %h", e.nm, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got %h want %h", e.nm, o, e.v); end
      end
    end
  endtask

  task automatic test_bus();
    exp_t e;
    logic [31:0] o;
    logic        exp_ack;
    wr(8'h20, 32'h0);
    push_exp("b2b_cmp", 32'h5); rd(8'h24);
    bus(1'b1, 8'h24, 32'hAABB_CCDD, 4'h1);
    push_exp("sel_byte0", 32'h0000_00DD); rd(8'h24);
    bus(1'b1, 8'h24, 32'h1122_3344, 4'h6);
    push_exp("sel_byte12", 32'h0022_33DD); rd(8'h24);
    push_exp("unmapped_e0", 32'h0); rd(8'hE0);
    push_exp("unmapped_14", 32'h0); rd(8'h14);
    wr(8'h40, 32'hFFFF_FFFF);
    push_exp("absent_ch2", 32'h0); rd(8'h40);
    push_exp("ch0_cmp_kept", 32'h15); rd(8'h04);
`ifndef TIMER_PWM_EN
    wr(8'h10, 32'hFFFF_FFFF);
    push_exp("duty_absent", 32'h0); rd(8'h10);
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: got no data want %h", e.nm, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got %h want %h", e.nm, o, e.v); end
      end
    end
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h04; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_ack = (i % 2 == 0);
      checks++;
      if (ack !== exp_ack) begin
        errors++; $display("FAIL ack_pattern[%0d]: got %b want %b", i, ack, exp_ack);
      end
      checks++;
      if (dat_o !== (exp_ack ? 32'h15 : 32'h0)) begin
        errors++; $display("FAIL dat_pattern[%0d]: got %h want %h", i, dat_o,
                           exp_ack ? 32'h15 : 32'h0);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
  endtask

`ifdef TIMER_PWM_EN
  task automatic test_pwm();
    exp_t e;
    logic [31:0] o;
    int hi;
    wr(8'h00, 32'h0);
    wr(8'h04, 32'h9);
    wr(8'h08, 32'h0);
    wr(8'h10, 32'h3);
    wr(8'h00, 32'h3);
    push_exp("duty_rd", 32'h3); rd(8'h10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: got no data want %h", e.nm, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got %h want %h", e.nm, o, e.v); end
      end
    end
    repeat (3) @(negedge clk);
    hi = 0;
    repeat (20) begin @(negedge clk); if (pwm[0]) hi++; end
    checks++;
    if (hi != 6) begin errors++; $display("FAIL pwm_duty3: got %0d high want 6", hi); end
    wr(8'h10, 32'h0);
    repeat (3) @(negedge clk);
    hi = 0;
    repeat (20) begin @(negedge clk); if (pwm[0]) hi++; end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL pwm_duty0: got %0d high want 0", hi); end
    wr(8'h10, 32'd12);
    repeat (3) @(negedge clk);
    hi = 0;
    repeat (20) begin @(negedge clk); if (pwm[0]) hi++; end
    checks++;
    if (hi != 20) begin errors++; $display("FAIL pwm_duty12: got %0d high want 20", hi); end
  endtask
`endif

  task automatic test_reset_mid();
    exp_t e;
    logic [31:0] o;
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h04; sel = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL mid_rst_ack: got %b want 0", ack); end
    checks++;
    if (dat_o !== 32'h0) begin errors++; $display("FAIL mid_rst_dat: got %h want 0", dat_o); end
    checks++;
    if (irq !== '0) begin errors++; $display("FAIL mid_rst_irq: got %b want 0", irq); end
    checks++;
    if (pwm !== '0) begin errors++; $display("FAIL mid_rst_pwm: got %b want 0", pwm); end
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    push_exp("mid_ctrl0", 32'h0);   rd(8'h00);
    push_exp("mid_count0", 32'h0);  rd(8'h08);
    push_exp("mid_cmp0", 32'h0);    rd(8'h04);
    push_exp("mid_status0", 32'h0); rd(8'h0C);
    push_exp("mid_count1", 32'h0);  rd(8'h28);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: got no data want %h", e.nm, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.v) begin errors++; $display("FAIL %s: got %h want %h", e.nm, o, e.v); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_boundaries();
    test_bus();
`ifdef TIMER_PWM_EN
    test_pwm();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
